// File: rtl/data_mem_stage.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : data_mem_stage
// Brief    : MEM-stage data memory with word/half/byte loads and stores,
//            combinational loads, clock-edge stores and address-error flag.
//            Optional store trace: define DM_WRITE_TRACE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_stage #(
   parameter int          ADDR_WIDTH = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        MemWriteM,
   input  logic        MemReadM,
   input  logic [2:0]  MemOpM,
   input  logic [31:0] AddrIn,
   input  logic [31:0] WriteDataIn,
   input  logic [31:0] PCIn,
   output logic [31:0] ReadDataOut,
   output logic        AddrErrOut
);

   localparam int         c_DEPTH      = 2**ADDR_WIDTH;
   localparam logic [2:0] c_OP_WORD    = 3'b001;
   localparam logic [2:0] c_OP_HALF_S  = 3'b010;
   localparam logic [2:0] c_OP_HALF_U  = 3'b011;
   localparam logic [2:0] c_OP_BYTE_S  = 3'b100;
   localparam logic [2:0] c_OP_BYTE_U  = 3'b101;

   logic [31:0]           r_mem [0:c_DEPTH-1];

   logic [31:0]           w_offset;
   logic [1:0]            w_lane;
   logic [ADDR_WIDTH-1:0] w_wordIdx;
   logic                  w_outOfRange;
   logic                  w_isWord;
   logic                  w_isHalf;
   logic                  w_isByte;
   logic                  w_signExt;
   logic                  w_opValid;
   logic                  w_access;
   logic                  w_misalign;
   logic                  w_storeEn;
   logic [31:0]           w_oldWord;
   logic [15:0]           w_half;
   logic [7:0]            w_byte;
   logic [31:0]           w_loadVal;
   logic [31:0]           w_newWord;

   assign w_offset     = AddrIn - BASE_ADDR;
   assign w_lane       = w_offset[1:0];
   assign w_wordIdx    = w_offset[ADDR_WIDTH+1:2];
   assign w_outOfRange = (AddrIn < BASE_ADDR) | (|w_offset[31:ADDR_WIDTH+2]);

   always_comb begin
      w_isWord  = 1'b0;
      w_isHalf  = 1'b0;
      w_isByte  = 1'b0;
      w_signExt = 1'b0;
      case (MemOpM)
         c_OP_WORD:   w_isWord = 1'b1;
         c_OP_HALF_S: begin w_isHalf = 1'b1; w_signExt = 1'b1; end
         c_OP_HALF_U: w_isHalf = 1'b1;
         c_OP_BYTE_S: begin w_isByte = 1'b1; w_signExt = 1'b1; end
         c_OP_BYTE_U: w_isByte = 1'b1;
         default:     ;
      endcase
   end

   assign w_opValid  = w_isWord | w_isHalf | w_isByte;
   assign w_access   = w_opValid & (MemReadM | MemWriteM);
   assign w_misalign = (w_isWord & (w_lane != 2'b00)) | (w_isHalf & w_lane[0]);
   assign AddrErrOut = w_access & (w_misalign | w_outOfRange);
   assign w_storeEn  = MemWriteM & w_opValid & ~AddrErrOut;

   assign w_oldWord  = r_mem[w_wordIdx];
   assign w_half     = w_lane[1] ? w_oldWord[31:16] : w_oldWord[15:0];

   always_comb begin
      w_byte = w_oldWord[7:0];
      case (w_lane)
         2'd1:    w_byte = w_oldWord[15:8];
         2'd2:    w_byte = w_oldWord[23:16];
         2'd3:    w_byte = w_oldWord[31:24];
         default: w_byte = w_oldWord[7:0];
      endcase
   end

   always_comb begin
      w_loadVal = w_oldWord;
      if (w_isHalf)
         w_loadVal = {{16{w_signExt & w_half[15]}}, w_half};
      else if (w_isByte)
         w_loadVal = {{24{w_signExt & w_byte[7]}}, w_byte};
   end

   // Reset gates the output too, so loads read 0 even before the array clears.
   assign ReadDataOut = (MemReadM & w_opValid & ~AddrErrOut & ~Reset) ? w_loadVal : 32'h0;

   // Merge store data into the current word so only addressed lanes change.
   always_comb begin
      w_newWord = w_oldWord;
      if (w_isWord) begin
         w_newWord = WriteDataIn;
      end else if (w_isHalf) begin
         if (w_lane[1]) w_newWord[31:16] = WriteDataIn[15:0];
         else           w_newWord[15:0]  = WriteDataIn[15:0];
      end else if (w_isByte) begin
         case (w_lane)
            2'd1:    w_newWord[15:8]  = WriteDataIn[7:0];
            2'd2:    w_newWord[23:16] = WriteDataIn[7:0];
            2'd3:    w_newWord[31:24] = WriteDataIn[7:0];
            default: w_newWord[7:0]   = WriteDataIn[7:0];
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < c_DEPTH; i++) r_mem[i] <= 32'h0;
      end else if (w_storeEn) begin
         r_mem[w_wordIdx] <= w_newWord;
      end
   end

`ifdef DM_WRITE_TRACE_EN
   always_ff @(posedge Clk) begin
      if (!Reset && w_storeEn)
         $display("@%h: *%h <= %h", PCIn, {AddrIn[31:2], 2'b00}, w_newWord);
   end
`else
   logic w_unusedPc;
   assign w_unusedPc = ^PCIn;
`endif

endmodule
`default_nettype wire
